lsu_ctrl: RTL and testbench

Load/store control unit between the CPU's memory-stage request and the data memory (combinational read, clocked byte/half/word write). It takes one load or store per valid/ready handshake and registers the request. It range-checks and alignment-checks the request, then drives the memory port. Loads return through a one-cycle response pulse, with optional splitting of misaligned accesses into byte transactions.

---
 rtl/lsu_ctrl.sv | 172 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store control unit: registers one CPU memory request, checks it, drives the data memory port.
// Optional LSU_MISALIGN_EN: misaligned in-range accesses are split into byte transactions.
module lsu_ctrl #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
`ifdef LSU_MISALIGN_EN
        S_SPLIT  = 2'd2,
`endif
        S_RESP   = 2'd3
    } state_t;

    state_t              r_state, w_next;
    logic                r_we, r_err;
    logic [2:0]          r_funct3;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata, r_rdata;

    logic [2:0]          w_size;
    logic [32:0]         w_end;
    logic                w_ill, w_oor, w_mis, w_err, w_acc;

    assign req_ready = (r_state == S_IDLE);
    assign w_acc     = req_valid && (r_state == S_IDLE);

    // Request checks are taken straight from the inputs being captured at the accept edge.
    always_comb begin
        case (req_funct3[1:0])
            2'b00:   w_size = 3'd1;
            2'b01:   w_size = 3'd2;
            default: w_size = 3'd4;
        endcase
        w_end = {1'b0, req_addr} + {30'd0, w_size} - 33'd1;
        w_oor = (|w_end[32:ADDR_W]) | (|req_addr[31:ADDR_W]);
        w_ill = req_we ? (req_funct3[2] || req_funct3 == 3'b011)
                       : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
        w_mis = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`ifdef LSU_MISALIGN_EN
        w_err = w_ill | w_oor;
`else
        w_err = w_ill | w_oor | w_mis;
`endif
    end

`ifdef LSU_MISALIGN_EN
    logic [1:0]  r_cnt;
    logic        w_last;
    logic [7:0]  w_byte;
    logic [31:0] w_asm;

    // Little-endian byte assembly; LH sign extension is applied on the final byte.
    always_comb begin
        w_last = (r_cnt == (r_funct3[1] ? 2'd3 : 2'd1));
        w_asm  = r_rdata;
        case (r_cnt)
            2'd0: begin w_byte = r_wdata[7:0];   w_asm[7:0]   = mem_rdata[7:0]; end
            2'd1: begin w_byte = r_wdata[15:8];  w_asm[15:8]  = mem_rdata[7:0]; end
            2'd2: begin w_byte = r_wdata[23:16]; w_asm[23:16] = mem_rdata[7:0]; end
            default: begin w_byte = r_wdata[31:24]; w_asm[31:24] = mem_rdata[7:0]; end
        endcase
        if (w_last && r_funct3 == 3'b001)
            w_asm[31:16] = {16{w_asm[15]}};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        rsp_valid  = 1'b0;
        rsp_err    = 1'b0;
        rsp_rdata  = 32'd0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_funct3 = 3'd0;
        mem_addr   = '0;
        mem_wdata  = 32'd0;
        case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    if (w_err)       w_next = S_RESP;
`ifdef LSU_MISALIGN_EN
                    else if (w_mis)  w_next = S_SPLIT;
`endif
                    else             w_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_read   = ~r_we;
                mem_write  = r_we;
                mem_funct3 = r_funct3;
                mem_addr   = r_addr;
                mem_wdata  = r_wdata;
                w_next     = S_RESP;
            end
`ifdef LSU_MISALIGN_EN
            S_SPLIT: begin
                mem_read   = ~r_we;
                mem_write  = r_we;
                mem_funct3 = r_we ? 3'b000 : 3'b100;
                mem_addr   = r_addr + ADDR_W'(r_cnt);
                mem_wdata  = {24'd0, w_byte};
                w_next     = w_last ? S_RESP : S_SPLIT;
            end
`endif
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = r_err;
                rsp_rdata = r_rdata;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
`ifdef LSU_MISALIGN_EN
            r_cnt    <= 2'd0;
`endif
        end else if (w_acc) begin
            r_we     <= req_we;
            r_err    <= w_err;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr[ADDR_W-1:0];
            r_wdata  <= req_wdata;
            r_rdata  <= 32'd0;
`ifdef LSU_MISALIGN_EN
            r_cnt    <= 2'd0;
`endif
        end else if (r_state == S_ACCESS && !r_we) begin
            r_rdata  <= mem_rdata;
`ifdef LSU_MISALIGN_EN
        end else if (r_state == S_SPLIT) begin
            r_cnt    <= r_cnt + 2'd1;
            if (!r_we) r_rdata <= w_asm;
`endif
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl with a byte-addressed memory model.
// Misaligned-split expectations follow LSU_MISALIGN_EN.
module tb_lsu_ctrl;
    localparam int ADDR_W = 9;

    logic              clk, rst_n;
    logic              req_valid, req_ready, req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr, req_wdata;
    logic              rsp_valid, rsp_err;
    logic [31:0]       rsp_rdata;
    logic              mem_read, mem_write;
    logic [2:0]        mem_funct3;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;

    lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational extended read, clocked sized write, plus a preload port.
    logic [7:0]  mem [0:511];
    logic        pre_we;
    logic [8:0]  pre_addr;
    logic [31:0] pre_data;
    logic [7:0]  b0, b1, b2, b3;

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr]        <= pre_data[7:0];
            mem[pre_addr + 9'd1] <= pre_data[15:8];
            mem[pre_addr + 9'd2] <= pre_data[23:16];
            mem[pre_addr + 9'd3] <= pre_data[31:24];
        end else if (mem_write) begin
            mem[mem_addr] <= mem_wdata[7:0];
            if (mem_funct3[1:0] != 2'b00) mem[mem_addr + 9'd1] <= mem_wdata[15:8];
            if (mem_funct3[1:0] == 2'b10) begin
                mem[mem_addr + 9'd2] <= mem_wdata[23:16];
                mem[mem_addr + 9'd3] <= mem_wdata[31:24];
            end
        end
    end

    always_comb begin
        b0 = mem[mem_addr];
        b1 = mem[mem_addr + 9'd1];
        b2 = mem[mem_addr + 9'd2];
        b3 = mem[mem_addr + 9'd3];
        case (mem_funct3)
            3'b000:  mem_rdata = {{24{b0[7]}}, b0};
            3'b001:  mem_rdata = {{16{b1[7]}}, b1, b0};
            3'b010:  mem_rdata = {b3, b2, b1, b0};
            3'b100:  mem_rdata = {24'd0, b0};
            3'b101:  mem_rdata = {16'd0, b1, b0};
            default: mem_rdata = 32'd0;
        endcase
    end

    int          total, bad;
    int          m_lat, m_nrd, m_nwr, m_rdybad;
    logic [31:0] m_rdata;
    logic        m_err;
    logic [8:0]  m_addr [0:3];
    logic [2:0]  m_f3 [0:3];

    task automatic preload(input logic [8:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    // Issue one request and observe until the response pulse (bounded at 12 cycles).
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int idx;
        idx = 0; m_lat = -1; m_nrd = 0; m_nwr = 0; m_rdybad = 0; m_rdata = 32'hDEADBEEF; m_err = 1'bx;
        for (int i = 0; i < 4; i++) begin m_addr[i] = '0; m_f3[i] = 3'b111; end
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (req_ready) m_rdybad++;
            if (mem_read) m_nrd++;
            if (mem_write) m_nwr++;
            if ((mem_read || mem_write) && idx < 4) begin
                m_addr[idx] = mem_addr; m_f3[idx] = mem_funct3; idx++;
            end
            if (rsp_valid) begin m_lat = k; m_rdata = rsp_rdata; m_err = rsp_err; break; end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (2) @(negedge clk);
        req_valid = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", req_ready); end
        total++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp got=%b%b exp=00", rsp_valid, rsp_err); end
        total++; if (rsp_rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", rsp_rdata); end
        total++; if ({mem_read, mem_write, mem_funct3} !== 5'd0) begin bad++; $display("FAIL rst_memctl got=%b%b%b exp=0", mem_read, mem_write, mem_funct3); end
        total++; if (mem_addr !== 9'd0 || mem_wdata !== 32'd0) begin bad++; $display("FAIL rst_memdata got=%h/%h exp=0/0", mem_addr, mem_wdata); end
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_release got=%b%b exp=10", req_ready, rsp_valid); end
    endtask

    task automatic test_load_store;
        preload(9'h100, 32'd17);
        run_req(1'b0, 3'b010, 32'h100, 32'h0);
        total++; if (m_lat !== 2) begin bad++; $display("FAIL lw_lat got=%0d exp=2", m_lat); end
        total++; if (m_rdata !== 32'h11 || m_err !== 1'b0) begin bad++; $display("FAIL lw_data got=%h/%b exp=00000011/0", m_rdata, m_err); end
        total++; if (m_nrd !== 1 || m_nwr !== 0) begin bad++; $display("FAIL lw_access got=%0d/%0d exp=1/0", m_nrd, m_nwr); end
        total++; if (m_addr[0] !== 9'h100 || m_f3[0] !== 3'b010) begin bad++; $display("FAIL lw_port got=%h/%b exp=100/010", m_addr[0], m_f3[0]); end
        total++; if (m_rdybad !== 0) begin bad++; $display("FAIL lw_ready got=%0d exp=0", m_rdybad); end
        run_req(1'b1, 3'b000, 32'h101, 32'h123456AB);
        total++; if (m_lat !== 2 || m_rdata !== 32'd0 || m_err !== 1'b0) begin bad++; $display("FAIL sb_rsp got=%0d/%h/%b exp=2/0/0", m_lat, m_rdata, m_err); end
        total++; if (m_nwr !== 1 || m_nrd !== 0) begin bad++; $display("FAIL sb_access got=%0d/%0d exp=1/0", m_nwr, m_nrd); end
        run_req(1'b0, 3'b010, 32'h100, 32'h0);
        total++; if (m_rdata !== 32'h0000AB11) begin bad++; $display("FAIL lw_after_sb got=%h exp=0000ab11", m_rdata); end
        run_req(1'b0, 3'b000, 32'h101, 32'h0);
        total++; if (m_rdata !== 32'hFFFFFFAB) begin bad++; $display("FAIL lb_sext got=%h exp=ffffffab", m_rdata); end
        run_req(1'b0, 3'b101, 32'h100, 32'h0);
        total++; if (m_rdata !== 32'h0000AB11) begin bad++; $display("FAIL lhu got=%h exp=0000ab11", m_rdata); end
    endtask

    task automatic test_misalign;
        preload(9'h100, 32'hFF000011);
        preload(9'h104, 32'h000000F0);
        run_req(1'b0, 3'b001, 32'h103, 32'h0);
`ifdef LSU_MISALIGN_EN
        total++; if (m_lat !== 3) begin bad++; $display("FAIL lh_split_lat got=%0d exp=3", m_lat); end
        total++; if (m_rdata !== 32'hFFFFF0FF || m_err !== 1'b0) begin bad++; $display("FAIL lh_split_data got=%h/%b exp=fffff0ff/0", m_rdata, m_err); end
        total++; if (m_nrd !== 2 || m_addr[0] !== 9'h103 || m_addr[1] !== 9'h104) begin bad++; $display("FAIL lh_split_addr got=%0d/%h/%h exp=2/103/104", m_nrd, m_addr[0], m_addr[1]); end
        total++; if (m_f3[0] !== 3'b100 || m_f3[1] !== 3'b100) begin bad++; $display("FAIL lh_split_f3 got=%b/%b exp=100/100", m_f3[0], m_f3[1]); end
        run_req(1'b0, 3'b101, 32'h103, 32'h0);
        total++; if (m_rdata !== 32'h0000F0FF) begin bad++; $display("FAIL lhu_split got=%h exp=0000f0ff", m_rdata); end
        run_req(1'b1, 3'b010, 32'h105, 32'hDDCCBBAA);
        total++; if (m_lat !== 5 || m_nwr !== 4 || m_rdata !== 32'd0) begin bad++; $display("FAIL sw_split got=%0d/%0d/%h exp=5/4/0", m_lat, m_nwr, m_rdata); end
        total++; if (m_addr[3] !== 9'h108 || m_f3[0] !== 3'b000) begin bad++; $display("FAIL sw_split_port got=%h/%b exp=108/000", m_addr[3], m_f3[0]); end
        run_req(1'b0, 3'b010, 32'h104, 32'h0);
        total++; if (m_rdata !== 32'hCCBBAAF0) begin bad++; $display("FAIL sw_split_rd got=%h exp=ccbbaaf0", m_rdata); end
        run_req(1'b0, 3'b100, 32'h108, 32'h0);
        total++; if (m_rdata !== 32'h000000DD) begin bad++; $display("FAIL sw_split_b3 got=%h exp=000000dd", m_rdata); end
`else
        total++; if (m_lat !== 1 || m_err !== 1'b1 || m_rdata !== 32'd0) begin bad++; $display("FAIL lh_mis_err got=%0d/%b/%h exp=1/1/0", m_lat, m_err, m_rdata); end
        total++; if (m_nrd !== 0) begin bad++; $display("FAIL lh_mis_noread got=%0d exp=0", m_nrd); end
        run_req(1'b1, 3'b010, 32'h105, 32'hDDCCBBAA);
        total++; if (m_err !== 1'b1 || m_nwr !== 0) begin bad++; $display("FAIL sw_mis_err got=%b/%0d exp=1/0", m_err, m_nwr); end
        run_req(1'b0, 3'b010, 32'h104, 32'h0);
        total++; if (m_rdata !== 32'h000000F0) begin bad++; $display("FAIL sw_mis_nowrite got=%h exp=000000f0", m_rdata); end
`endif
    endtask

    task automatic test_errors;
        run_req(1'b0, 3'b010, 32'h200, 32'h0);
        total++; if (m_lat !== 1 || m_err !== 1'b1 || m_nrd !== 0) begin bad++; $display("FAIL err_oor got=%0d/%b/%0d exp=1/1/0", m_lat, m_err, m_nrd); end
        run_req(1'b0, 3'b010, 32'h1FE, 32'h0);
        total++; if (m_err !== 1'b1 || m_nrd !== 0 || m_rdata !== 32'd0) begin bad++; $display("FAIL err_span got=%b/%0d/%h exp=1/0/0", m_err, m_nrd, m_rdata); end
        run_req(1'b1, 3'b100, 32'h100, 32'hFFFFFFFF);
        total++; if (m_err !== 1'b1 || m_nwr !== 0) begin bad++; $display("FAIL err_st_f3 got=%b/%0d exp=1/0", m_err, m_nwr); end
        run_req(1'b0, 3'b011, 32'h100, 32'h0);
        total++; if (m_err !== 1'b1 || m_nrd !== 0) begin bad++; $display("FAIL err_ld_f3 got=%b/%0d exp=1/0", m_err, m_nrd); end
        run_req(1'b0, 3'b010, 32'h80000100, 32'h0);
        total++; if (m_err !== 1'b1 || m_lat !== 1) begin bad++; $display("FAIL err_hibits got=%b/%0d exp=1/1", m_err, m_lat); end
        preload(9'h1FC, 32'hCAFEF00D);
        run_req(1'b0, 3'b010, 32'h1FC, 32'h0);
        total++; if (m_err !== 1'b0 || m_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL top_word got=%b/%h exp=0/cafef00d", m_err, m_rdata); end
    endtask

    task automatic test_back_to_back;
        int pulses;
        pulses = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h1FC; req_wdata = 32'd0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (rsp_valid) pulses++;
        end
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (pulses !== 3) begin bad++; $display("FAIL b2b_rate got=%0d exp=3", pulses); end
    endtask

    task automatic test_reset_mid;
        int seen;
        logic [31:0] word;
        seen = 0;
        preload(9'h110, 32'h01020304);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h110; req_wdata = 32'hAAAAAAAA;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        total++; if (mem_write !== 1'b1) begin bad++; $display("FAIL mid_access got=%b exp=1", mem_write); end
        rst_n = 1'b0;
        #1;
        total++; if (mem_write !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL mid_async got=%b/%b exp=0/1", mem_write, req_ready); end
        repeat (2) begin @(negedge clk); if (rsp_valid) seen++; end
        rst_n = 1'b1;
        repeat (3) begin @(negedge clk); if (rsp_valid) seen++; end
        word = {mem[9'h113], mem[9'h112], mem[9'h111], mem[9'h110]};
        total++; if (seen !== 0) begin bad++; $display("FAIL mid_norsp got=%0d exp=0", seen); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", req_ready); end
        total++; if (word !== 32'h01020304) begin bad++; $display("FAIL mid_mem got=%h exp=01020304", word); end
        run_req(1'b0, 3'b010, 32'h110, 32'h0);
        total++; if (m_lat !== 2 || m_rdata !== 32'h01020304) begin bad++; $display("FAIL mid_recover got=%0d/%h exp=2/01020304", m_lat, m_rdata); end
    endtask

    initial begin
        total = 0; bad = 0;
        test_reset();
        test_load_store();
        test_misalign();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
